// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - RAM BIST sequencer: two complementary write/read-back passes with mismatch reporting
module ram_bist_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [5:0]        o_err_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data,
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RD_LAT - 1);

  state_t r_state;
  state_t w_next;

  logic                           r_phase;
  logic [ADDR_W-1:0]              r_addr;
  logic [1:0]                     r_drain;
  logic [5:0]                     r_err;
  logic                           r_have_fail;
  logic [ADDR_W-1:0]              r_fail_addr;
  logic [DATA_W-1:0]              r_fail_data;
  logic [RD_LAT-1:0]              r_pv;
  logic [RD_LAT-1:0][ADDR_W-1:0]  r_pa;
  logic [RD_LAT-1:0][DATA_W-1:0]  r_pe;

  logic              w_last_addr;
  logic              w_drain_end;
  logic              w_accept;
  logic [DATA_W-1:0] w_p0;
  logic [DATA_W-1:0] w_pattern;
  logic              w_mismatch;

  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_drain_end = (r_drain == LAST_DRAIN);
  assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_p0        = DATA_W'(r_addr);
  assign w_pattern   = r_phase ? ~w_p0 : w_p0;
  // Oldest pipe entry lines up with the RAM data for the read issued RD_LAT cycles ago.
  assign w_mismatch  = r_pv[RD_LAT-1] && (i_ram_dout != r_pe[RD_LAT-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_pass     = 1'b0;
    o_ram_rd   = 1'b0;
    o_ram_wr   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_WR;
      end
      S_WR: begin
        o_busy     = 1'b1;
        o_ram_wr   = 1'b1;
        o_ram_addr = r_addr;
        o_ram_data = w_pattern;
        if (w_last_addr) w_next = S_RD;
      end
      S_RD: begin
        o_busy     = 1'b1;
        o_ram_rd   = 1'b1;
        o_ram_addr = r_addr;
        if (w_last_addr) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_drain_end) w_next = r_phase ? S_DONE : S_WR;
      end
      S_DONE: begin
        o_done = 1'b1;
        o_pass = (r_err == 6'd0);
        if (i_start) w_next = S_WR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_drain     <= '0;
      r_err       <= '0;
      r_have_fail <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_pv        <= '0;
      r_pa        <= '0;
      r_pe        <= '0;
    end else begin
      if (w_accept) begin
        r_phase     <= 1'b0;
        r_addr      <= '0;
        r_drain     <= '0;
        r_err       <= '0;
        r_have_fail <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end

      case (r_state)
        S_WR, S_RD: r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
        S_DRAIN: begin
          if (w_drain_end) begin
            r_drain <= '0;
            r_phase <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: ;
      endcase

      r_pv[0] <= (r_state == S_RD);
      r_pa[0] <= r_addr;
      r_pe[0] <= w_pattern;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pe[i] <= r_pe[i-1];
      end

      if (w_mismatch) begin
        if (r_err != 6'd63) r_err <= r_err + 6'd1;
        if (!r_have_fail) begin
          r_have_fail <= 1'b1;
          r_fail_addr <= r_pa[RD_LAT-1];
          r_fail_data <= i_ram_dout;
        end
      end
    end
  end

  assign o_err_count = r_err;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - scoreboard bench for ram_bist_ctrl with faulty-RAM models
module tb_ram_bist_ctrl;

  typedef struct {int cyc; int err; int fa; int fd; int pass;} exp_t;
  typedef struct {int a; int d;} wexp_t;
  typedef struct {int err; int fa; int fd; int pass;} res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // fault mode: 0 ideal, 1 stuck bit, 2 address bit 4 ignored, 3 dout constant 0x55
  int md = 0, sa = 0, sb = 0, sv = 0;

  logic       busy, done, pass, rd, wr;
  logic [5:0] err;
  logic [4:0] fa, addr;
  logic [7:0] fd, wdata, dout;
  logic       busy2, done2, pass2, rd2, wr2;
  logic [5:0] err2;
  logic [4:0] fa2, addr2;
  logic [7:0] fd2, wdata2, dout2, q2;
  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];

  exp_t  dq1[$];
  exp_t  dq2[$];
  wexp_t wq[$];

  ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_err_count(err), .o_fail_addr(fa), .o_fail_data(fd),
    .o_ram_rd(rd), .o_ram_wr(wr), .o_ram_addr(addr), .o_ram_data(wdata), .i_ram_dout(dout));

  ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
    .o_pass(pass2), .o_err_count(err2), .o_fail_addr(fa2), .o_fail_data(fd2),
    .o_ram_rd(rd2), .o_ram_wr(wr2), .o_ram_addr(addr2), .o_ram_data(wdata2), .i_ram_dout(dout2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff(int m, int a);
    return (m == 2) ? (a & 15) : a;
  endfunction

  function automatic logic [7:0] store(int m, int s_a, int s_b, int s_v, int pa, logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (m == 1 && pa == s_a) r[s_b] = s_v[0];
    return r;
  endfunction

  function automatic logic [7:0] pat(int ph, int a);
    logic [7:0] p;
    p = 8'(a);
    return (ph != 0) ? ~p : p;
  endfunction

  // Whole-test outcome from the RAM's fault behaviour: write array, read back, count.
  function automatic res_t model(int m, int s_a, int s_b, int s_v);
    logic [7:0] mm [32];
    logic [7:0] rv;
    int nerr;
    bit got;
    res_t r;
    nerr = 0; got = 0; r.fa = 0; r.fd = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 32; a++) mm[eff(m, a)] = store(m, s_a, s_b, s_v, eff(m, a), pat(ph, a));
      for (int a = 0; a < 32; a++) begin
        rv = (m == 3) ? 8'h55 : mm[eff(m, a)];
        if (rv != pat(ph, a)) begin
          nerr++;
          if (!got) begin got = 1; r.fa = a; r.fd = int'(rv); end
        end
      end
    end
    r.err  = (nerr > 63) ? 63 : nerr;
    r.pass = (nerr == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  always @(posedge clk) begin
    if (wr) mem1[eff(md, int'(addr))] <= store(md, sa, sb, sv, eff(md, int'(addr)), wdata);
    if (rd) dout <= (md == 3) ? 8'h55 : mem1[eff(md, int'(addr))];
  end

  always @(posedge clk) begin
    if (wr2) mem2[addr2] <= wdata2;
    if (rd2) q2 <= mem2[addr2];
    dout2 <= q2;
  end

  always begin : mon1
    wexp_t w;
    exp_t  e;
    logic  prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("strobe_overlap", {31'd0, rd & wr}, 32'd0);
        if (wr) begin
          if (wq.size() == 0) miss("wr_unexpected");
          else begin
            w = wq.pop_front();
            chk("wr_addr", {27'd0, addr}, w.a);
            chk("wr_data", {24'd0, wdata}, w.d);
          end
        end
        if (done && !prev) begin
          if (dq1.size() == 0) miss("done_unexpected");
          else begin
            e = dq1.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("err_count", {26'd0, err}, e.err);
            chk("fail_addr", {27'd0, fa}, e.fa);
            chk("fail_data", {24'd0, fd}, e.fd);
            chk("pass", {31'd0, pass}, e.pass);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
          end
        end
        prev = done;
      end else begin
        prev = 1'b0;
      end
    end
  end

  always begin : mon2
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("lat2_strobe_overlap", {31'd0, rd2 & wr2}, 32'd0);
        if (done2 && !prev) begin
          if (dq2.size() == 0) miss("lat2_done_unexpected");
          else begin
            e = dq2.pop_front();
            chk("lat2_done_cycle", cyc, e.cyc);
            chk("lat2_err_count", {26'd0, err2}, e.err);
            chk("lat2_pass", {31'd0, pass2}, e.pass);
          end
        end
        prev = done2;
      end else begin
        prev = 1'b0;
      end
    end
  end

  task automatic run1(input int m, input int a, input int b, input int v, input bit repulse, input int abort_at);
    exp_t  e;
    res_t  r;
    wexp_t w;
    int    n0;
    int    k;
    md = m; sa = a; sb = b; sv = v;
    r = model(m, a, b, v);
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < 32; i++) begin
        w.a = i;
        w.d = int'(pat(ph, i));
        wq.push_back(w);
      end
    @(negedge clk);
    start = 1'b1;
    n0 = cyc + 1;
    if (abort_at == 0) begin
      e.cyc = n0 + 2 * (2 * 32 + 1); e.err = r.err; e.fa = r.fa; e.fd = r.fd; e.pass = r.pass;
      dq1.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_cleared", {10'd0, done, pass, err, fa, fd}, 32'd0);
    chk("c1_wr_addr0", {26'd0, wr, addr}, 32'h20);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
      start = repulse && (k == 20);
      if (abort_at != 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_status", {10'd0, busy, done, pass, err, fa, fd}, 32'd0);
        chk("abort_ram", {17'd0, rd, wr, addr, wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        return;
      end
    end
    if (!done) miss("done_timeout");
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n0;
    int   k;
    repeat (2) @(negedge clk);
    chk("rst_status", {10'd0, busy, done, pass, err, fa, fd}, 32'd0);
    chk("rst_ram", {17'd0, rd, wr, addr, wdata}, 32'd0);
    chk("rst_lat2", {9'd0, busy2, done2, pass2, err2, rd2, wr2, addr2, wdata2}, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    start2 = 1'b1;
    n0 = cyc + 1;
    e.cyc = n0 + 2 * (2 * 32 + 2); e.err = 0; e.fa = 0; e.fd = 0; e.pass = 1;
    dq2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!done2) miss("lat2_done_timeout");

    run1(0, 0, 0, 0, 1'b1, 0);
    run1(1, 8, 3, 0, 1'b0, 0);
    run1(2, 0, 0, 0, 1'b0, 0);
    run1(3, 0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      run1(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0, 0);
    run1(0, 0, 0, 0, 1'b0, 40);
    run1(0, 0, 0, 0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("queues_drained", dq1.size() + dq2.size() + wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test sequencer that sits directly upstream of the 32x8 RAM and drives its rd/wr/addr/data inputs while consuming its dout. On a start pulse it runs two full-array write/read-back passes with complementary patterns, compares every word, and reports pass/fail, the first failing address and data, and a mismatch count. Used at bring-up and in regression to qualify the RAM without a testbench driving it directly.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 8, RAM data width
- DEPTH, 32, words tested; equals 2**ADDR_W
- RD_LAT, 1, cycles from ram_rd=1 edge to valid ram_dout (1..3)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset immediately
- start  in  1  one-cycle request to begin a test; sampled in IDLE or DONE only
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start or reset
- pass  out  1  done and zero mismatches
- err_count  out  6  mismatches counted, saturating at 63
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  ram_dout captured at first mismatch
- ram_rd  out  1  RAM read strobe
- ram_wr  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_data  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data

## Operation
- States: IDLE, WR, RD, DRAIN, DONE; 1-bit phase register (0 = pattern P0, 1 = pattern P1).
- P0(a) = a zero-extended to DATA_W; P1(a) = ~P0(a).
- IDLE/DONE + start=1: clear err_count, fail_addr, fail_data, done, pass; phase=0, addr=0; go WR.
- WR: ram_wr=1, ram_data=P(phase)(addr), addr++ each cycle; after addr DEPTH-1, addr=0, go RD.
- RD: ram_rd=1, addr++ each cycle; expected value and address enter an RD_LAT-deep shift pipe alongside the read; after DEPTH-1 go DRAIN.
- DRAIN: RD_LAT cycles, no strobes, pipe empties. Then phase 0 -> phase=1, addr=0, WR; phase 1 -> DONE.
- Compare: when a pipe entry emerges valid, ram_dout != expected -> err_count++ (saturate 63); if first mismatch of run, latch fail_addr and fail_data.
- DONE: busy=0, done=1, pass=(err_count==0). Strobes 0.
- ram_rd and ram_wr never both 1. Outside WR/RD both 0; ram_addr, ram_data held at 0 when idle.
- start while busy: ignored, no effect.
- Reset (any time, mid-run included): state IDLE, phase 0, pipe cleared; all outputs 0 (busy, done, pass, err_count, fail_addr, fail_data, ram_rd, ram_wr, ram_addr, ram_data).

## Timing
- Start sampled at edge E0; cycle 1 = first cycle after E0: busy=1, ram_wr=1, ram_addr=0.
- Per pass: DEPTH write cycles, DEPTH read cycles, RD_LAT drain cycles.
- RD_LAT=1, DEPTH=32: P0 writes cycles 1-32, reads 33-64, drain 65; P1 writes 66-97, reads 98-129, drain 130; done=1, busy=0 from cycle 131.
- General: done rises 2*(2*DEPTH+RD_LAT)+1 cycles after E0.
- Read issued in cycle c is compared against ram_dout in cycle c+RD_LAT.
- err_count/fail_* update at the edge ending the compare cycle; fail_* never overwritten after first latch within a run.
- Restart from DONE: same sequence, outputs cleared cycle 1.

## Test plan
- Ideal RAM model, RD_LAT=1, start pulse -> ram_wr on addr 0..31 with data 0x00..0x1F then 0xFF..0xE0; done at cycle 131; pass=1, err_count=0, fail_addr=0, fail_data=0.
- RAM with bit 3 stuck-at-0 at addr 8 -> pass=0, err_count=1, fail_addr=8, fail_data=0x00.
- RAM ignoring addr bit 4 (aliasing) -> err_count=32, fail_addr=0, fail_data=0x10, pass=0.
- ram_dout forced constant 0x55 -> err_count saturates 63 (64 mismatches), fail_addr=0, fail_data=0x55.
- start re-pulsed at cycle 20 -> ignored, done still at cycle 131; reset=0 at cycle 40 -> all outputs 0 same cycle; new start then completes with pass=1 after 131 cycles.
- RD_LAT=2 with 2-cycle RAM model -> done at cycle 133, pass=1; no read/write strobe overlap at any cycle.
